// File: rtl/regfile_arb_pkg.sv
// Purpose: shared widths, the zero-register constant and the write-back request type for the RF write arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Writes to this register are acknowledged but never reach the register file.
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: N-way round-robin arbiter; one-hot grant and its index, pointer advances past each winner.
// Latency: grant is combinational from req (same cycle); pointer updates on the rising edge.
// Backpressure: never stalls; the winner is always granted, losers see grant=0 and keep requesting.
//
// Ports: clk, resetN (async active-low), req[N] requests in,
//        grant[N] one-hot grant out, grant_idx index of the granted bit (0 when nothing granted).
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               pos;

    // Scan from the pointer upward, wrapping modulo N; first requester seen wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = IDX_W'(pos);
            end
        end
        // No requester may be acknowledged while reset is held.
        if (!resetN) begin
            grant     = '0;
            grant_idx = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Purpose: shares the single register-file write port between NUM_REQ write-back sources (round-robin).
// Latency: accept is combinational (reqReady same cycle); the write appears on regWrite/wrReg/wrData one cycle later.
// Backpressure: one accept per cycle; output stage never stalls; non-granted requesters hold valid until ready.
//
// Ports: clk, resetN (async active-low);
//        reqValid/reqReg/reqData  packed per-requester write requests, lane i at [i*W +: W];
//        reqReady                 one-hot accept; grantIdx index of accepted lane (0 when none);
//        regWrite/wrReg/wrData    registered register-file write port;
//        pendMask                 one-hot of wrReg while regWrite is high, for hazard logic;
//        conflictCnt              saturating count of cycles with two or more requests.
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] reqReg,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         wrReg,
    output logic [DATA_W-1:0]         wrData,
    output logic [IDX_W-1:0]          grantIdx,
    output logic [2**ADDR_W-1:0]      pendMask,
    output logic [CNT_W-1:0]          conflictCnt
);

    logic                 accept;
    logic                 squash;
    logic                 multi_req;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_data;
    logic [2**ADDR_W-1:0] pend_nxt;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .resetN    (resetN),
        .req       (reqValid),
        .grant     (reqReady),
        .grant_idx (grantIdx)
    );

    assign accept = |reqReady;

    // Select by the one-hot grant so undriven/X lanes of idle requesters never reach the output stage.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqReady[i]) begin
                sel_addr = reqReg[i*ADDR_W +: ADDR_W];
                sel_data = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign squash = (sel_addr == ADDR_W'(ZERO_REG));

    always_comb begin
        pend_nxt = '0;
        if (accept && !squash) begin
            pend_nxt[sel_addr] = 1'b1;
        end
    end

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multi_req = |(reqValid & (reqValid - NUM_REQ'(1)));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            regWrite <= 1'b0;
            wrReg    <= '0;
            wrData   <= '0;
            pendMask <= '0;
        end else begin
            pendMask <= pend_nxt;
            if (accept) begin
                regWrite <= !squash;
                wrReg    <= sel_addr;
                wrData   <= sel_data;
            end else begin
                regWrite <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            conflictCnt <= '0;
        end else if (multi_req && (conflictCnt != {CNT_W{1'b1}})) begin
            conflictCnt <= conflictCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
    import regfile_arb_pkg::*;

    localparam int NR = 2;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk;
    logic              resetN;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_reg;
    logic [NR*DW-1:0]  req_data;

    logic [NR-1:0]     rdy,  rdy_s;
    logic              rw,   rw_s;
    logic [AW-1:0]     wr,   wr_s;
    logic [DW-1:0]     wd,   wd_s;
    logic              gi,   gi_s;
    logic [31:0]       pm,   pm_s;
    logic [15:0]       cnt;
    logic [3:0]        cnt_s;

    int tests_run;
    int tests_failed;

    // Reference model state (follows the behavioural rules, not the RTL structure).
    int           m_ptr;
    logic         m_rw;
    logic [4:0]   m_wr;
    logic [31:0]  m_wd;
    logic [31:0]  m_pm;
    int           m_cnt;

    regfile_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .resetN(resetN), .reqValid(req_valid), .reqReg(req_reg), .reqData(req_data),
        .reqReady(rdy), .regWrite(rw), .wrReg(wr), .wrData(wd), .grantIdx(gi),
        .pendMask(pm), .conflictCnt(cnt)
    );

    regfile_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut_sat (
        .clk(clk), .resetN(resetN), .reqValid(req_valid), .reqReg(req_reg), .reqData(req_data),
        .reqReady(rdy_s), .regWrite(rw_s), .wrReg(wr_s), .wrData(wd_s), .grantIdx(gi_s),
        .pendMask(pm_s), .conflictCnt(cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    function automatic int model_pick();
        int i;
        for (int k = 0; k < NR; k++) begin
            i = (m_ptr + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic int sat(int c, int maxv);
        return (c > maxv) ? maxv : c;
    endfunction

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        int g;
        r = '0;
        g = model_pick();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_rw = 0; m_wr = '0; m_wd = '0; m_pm = '0; m_cnt = 0;
    endtask

    task automatic set_lane(int i, logic v, wb_req_t r);
        req_valid[i] = v;
        req_reg[i*AW +: AW]  = v ? r.addr : 'x;
        req_data[i*DW +: DW] = v ? r.data : 'x;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NR; i++) set_lane(i, 1'b0, '0);
    endtask

    // Advance one clock: update the model from the inputs present at the edge, then settle past it.
    task automatic tick();
        int g;
        logic [4:0] a;
        g = model_pick();
        if (g >= 0) begin
            a     = req_reg[g*AW +: AW];
            m_wr  = a;
            m_wd  = req_data[g*DW +: DW];
            m_rw  = (a != 5'd0);
            m_pm  = m_rw ? (32'd1 << a) : 32'd0;
            m_ptr = (g + 1) % NR;
        end else begin
            m_rw = 1'b0;
            m_pm = '0;
        end
        if ($countones(req_valid) >= 2) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetN = 1'b0;
        #2;
        model_reset();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        set_lane(0, 1'b1, '{addr: 5'd3, data: 32'h1});
        set_lane(1, 1'b1, '{addr: 5'd4, data: 32'h2});
        #2;
        tests_run++; if (rdy !== 2'b00)  begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", rdy); end
        tests_run++; if (rw !== 1'b0)    begin tests_failed++; $display("FAIL reset_regwrite got=%b exp=0", rw); end
        tests_run++; if (wr !== 5'd0)    begin tests_failed++; $display("FAIL reset_wrreg got=%0d exp=0", wr); end
        tests_run++; if (wd !== 32'd0)   begin tests_failed++; $display("FAIL reset_wrdata got=%h exp=0", wd); end
        tests_run++; if (pm !== 32'd0)   begin tests_failed++; $display("FAIL reset_pendmask got=%h exp=0", pm); end
        tests_run++; if (cnt !== 16'd0)  begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        do_reset();
    endtask

    task automatic test_single();
        set_lane(0, 1'b1, '{addr: 5'd5, data: 32'hDEADBEEF});
        #1;
        tests_run++; if (rdy !== 2'b01) begin tests_failed++; $display("FAIL single_ready got=%b exp=01", rdy); end
        tests_run++; if (gi !== 1'b0)   begin tests_failed++; $display("FAIL single_gidx got=%0d exp=0", gi); end
        tick();
        idle_inputs();
        tests_run++; if (rw !== 1'b1)          begin tests_failed++; $display("FAIL single_regwrite got=%b exp=1", rw); end
        tests_run++; if (wr !== 5'd5)          begin tests_failed++; $display("FAIL single_wrreg got=%0d exp=5", wr); end
        tests_run++; if (wd !== 32'hDEADBEEF)  begin tests_failed++; $display("FAIL single_wrdata got=%h exp=deadbeef", wd); end
        tests_run++; if (pm !== 32'h20)        begin tests_failed++; $display("FAIL single_pendmask got=%h exp=00000020", pm); end
        tick();
        tests_run++; if (rw !== 1'b0)          begin tests_failed++; $display("FAIL single_idle_regwrite got=%b exp=0", rw); end
    endtask

    task automatic test_contention();
        logic [4:0] er;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            set_lane(0, 1'b1, '{addr: 5'(2*c + 1), data: $urandom});
            set_lane(1, 1'b1, '{addr: 5'(2*c + 2), data: $urandom});
            #1;
            tests_run++;
            if (rdy !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++; $display("FAIL contention_grant c=%0d got=%b exp=%b", c, rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            er = (c % 2 == 0) ? 5'(2*c + 1) : 5'(2*c + 2);
            tick();
            tests_run++; if (rw !== 1'b1 || wr !== er) begin tests_failed++; $display("FAIL contention_write c=%0d got=%b/%0d exp=1/%0d", c, rw, wr, er); end
        end
        idle_inputs();
        tests_run++; if (cnt !== 16'd6)  begin tests_failed++; $display("FAIL contention_cnt got=%0d exp=6", cnt); end
        tests_run++; if (cnt_s !== 4'd6) begin tests_failed++; $display("FAIL contention_cnt4 got=%0d exp=6", cnt_s); end
    endtask

    task automatic test_zero_reg();
        set_lane(1, 1'b1, '{addr: 5'd0, data: 32'h1234});
        #1;
        tests_run++; if (rdy !== 2'b10) begin tests_failed++; $display("FAIL zero_ready got=%b exp=10", rdy); end
        tick();
        idle_inputs();
        tests_run++; if (rw !== 1'b0)  begin tests_failed++; $display("FAIL zero_regwrite got=%b exp=0", rw); end
        tests_run++; if (pm !== 32'd0) begin tests_failed++; $display("FAIL zero_pendmask got=%h exp=0", pm); end
        set_lane(0, 1'b1, '{addr: 5'd9, data: 32'h9});
        set_lane(1, 1'b1, '{addr: 5'd10, data: 32'hA});
        #1;
        tests_run++; if (rdy !== 2'b01) begin tests_failed++; $display("FAIL zero_ptr_wrap got=%b exp=01", rdy); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_idle_gaps();
        logic ev;
        logic [4:0] er;
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      set_lane(0, 1'b1, '{addr: 5'd7, data: 32'h77});
            else if (c == 3) set_lane(0, 1'b1, '{addr: 5'd9, data: 32'h99});
            else             idle_inputs();
            tick();
            ev = (c == 0 || c == 3);
            er = (c < 3) ? 5'd7 : 5'd9;
            tests_run++;
            if (rw !== ev || wr !== er || wd !== ((c < 3) ? 32'h77 : 32'h99)) begin
                tests_failed++; $display("FAIL gap_cycle%0d got rw=%b reg=%0d data=%h exp rw=%b reg=%0d", c + 1, rw, wr, wd, ev, er);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        set_lane(0, 1'b1, '{addr: 5'd12, data: 32'hC});
        set_lane(1, 1'b1, '{addr: 5'd13, data: 32'hD});
        tick();
        tests_run++; if (rw !== 1'b1 || cnt === 16'd0) begin tests_failed++; $display("FAIL areset_pre got rw=%b cnt=%0d exp rw=1 cnt>0", rw, cnt); end
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        tests_run++; if (rw !== 1'b0)   begin tests_failed++; $display("FAIL areset_regwrite got=%b exp=0", rw); end
        tests_run++; if (pm !== 32'd0)  begin tests_failed++; $display("FAIL areset_pendmask got=%h exp=0", pm); end
        tests_run++; if (cnt !== 16'd0) begin tests_failed++; $display("FAIL areset_cnt got=%0d exp=0", cnt); end
        tests_run++; if (rdy !== 2'b00) begin tests_failed++; $display("FAIL areset_ready got=%b exp=00", rdy); end
        #2;
        resetN = 1'b1;
        #1;
        tests_run++; if (rdy !== 2'b01) begin tests_failed++; $display("FAIL areset_first_grant got=%b exp=01", rdy); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        set_lane(0, 1'b1, '{addr: 5'd1, data: 32'h1});
        set_lane(1, 1'b1, '{addr: 5'd2, data: 32'h2});
        for (int c = 0; c < 20; c++) tick();
        idle_inputs();
        tests_run++; if (cnt_s !== 4'd15) begin tests_failed++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt_s); end
        tests_run++; if (cnt !== 16'd20)  begin tests_failed++; $display("FAIL sat_cnt16 got=%0d exp=20", cnt); end
        tick();
        tests_run++; if (cnt_s !== 4'd15) begin tests_failed++; $display("FAIL sat_hold got=%0d exp=15", cnt_s); end
    endtask

    task automatic test_random();
        logic [NR-1:0] er;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                // Bias toward low registers so the zero-register squash shows up often.
                set_lane(i, 1'($urandom_range(0, 1)),
                         '{addr: ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), data: $urandom});
            end
            #1;
            er = exp_ready();
            tests_run++;
            if (rdy !== er || gi !== ((er == 2'b10) ? 1'b1 : 1'b0)) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_grant c=%0d got=%b/%0d exp=%b", c, rdy, gi, er);
            end
            tick();
            tests_run++;
            if (rw !== m_rw || wr !== m_wr || wd !== m_wd || pm !== m_pm ||
                cnt !== 16'(sat(m_cnt, 65535)) || cnt_s !== 4'(sat(m_cnt, 15))) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_out c=%0d got rw=%b reg=%0d data=%h pm=%h cnt=%0d/%0d exp rw=%b reg=%0d data=%h pm=%h cnt=%0d",
                                        c, rw, wr, wd, pm, cnt, cnt_s, m_rw, m_wr, m_wd, m_pm, m_cnt);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_reset();
        resetN    = 1'b0;
        req_valid = '0;
        req_reg   = '0;
        req_data  = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero_reg();
        test_idle_gaps();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (regWrite / wrReg / wrData) between NUM_REQ write-back sources, e.g. ALU result and load data.
- Arbitration is round-robin with a valid/ready handshake per requester. One write is accepted per cycle and registered into an output stage that drives the register file.
- Also publishes a pending-write mask for hazard logic, and a saturating contention counter.

Parameters:
- NUM_REQ, 2, number of write-back requesters (2..8).
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- reqValid  input  NUM_REQ  per-requester write request.
- reqReg  input  NUM_REQ*ADDR_W  packed destination register; requester i at bits [i*ADDR_W +: ADDR_W].
- reqData  input  NUM_REQ*DATA_W  packed write data, same packing.
- reqReady  output  NUM_REQ  one-hot grant; the request is accepted when reqValid[i] & reqReady[i].
- regWrite  output  1  write enable to the register file.
- wrReg  output  ADDR_W  write address to the register file.
- wrData  output  DATA_W  write data to the register file.
- grantIdx  output  $clog2(NUM_REQ)  index of the requester accepted this cycle (valid when |reqReady).
- pendMask  output  2**ADDR_W  bit r set while a write to register r sits in the output stage.
- conflictCnt  output  CNT_W  count of cycles with more than one reqValid asserted; saturating.

Behaviour:
- Reset (async, resetN=0):
  - regWrite=0, wrReg=0, wrData=0, pendMask=0, conflictCnt=0.
  - Round-robin pointer=0.
  - reqReady=0 while in reset.
- Arbitration (combinational):
  - Search starts at the pointer and wraps modulo NUM_REQ. The first i with reqValid[i]=1 gets reqReady[i]=1; all other ready bits are 0.
  - No valid requests -> reqReady=0, grantIdx=0.
  - Ready depends on valid. Requesters must not make valid depend on ready.
- Pointer update: on an accepted cycle, pointer <= grantIdx+1, wrapping NUM_REQ-1 -> 0. Otherwise the pointer holds.
- Output stage (latency 1):
  - On accept: wrReg <= reqReg[grantIdx], wrData <= reqData[grantIdx], regWrite <= 1.
  - With no accept: regWrite <= 0, and wrReg/wrData hold their previous values.
- Register 0 squash: an accepted request with reqReg=0 is still acknowledged (reqReady=1), but regWrite <= 0 that cycle and pendMask is unaffected.
- pendMask is the one-hot decode of wrReg when regWrite=1, else 0. It is registered together with the output stage, so it carries no extra latency.
- Back-to-back: the port sustains one write per cycle. The output stage never stalls, because the register file always accepts.
- Requester ordering: writes from the same requester are applied in acceptance order. No ordering is guaranteed between different requesters to the same register beyond acceptance order.
- Contention: conflictCnt increments in every cycle where popcount(reqValid) >= 2. It saturates at 2**CNT_W-1 and never wraps.
- Reset asserted mid-stream: the in-flight output-stage write is dropped (regWrite=0 immediately). The pointer returns to 0.
- reqReg/reqData of requesters that are not granted are ignored. X on non-valid lanes must not propagate to the outputs.

Decomposition:
- Package regfile_arb_pkg holds:
  - localparams REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG='0;
  - typedef wb_req_t {addr, data}.
- Sub-module rr_arbiter (parameter N) holds the pointer register, the rotate/priority-pick logic, and the one-hot grant plus index output. It is reusable for other shared resources.
- regfile_wr_arbiter instantiates rr_arbiter and contains the mux, the output stage, the squash logic, pendMask and the counter.

Test Plan:
- Reset then single request: reqValid=01, reqReg[0]=5, reqData[0]=0xDEADBEEF -> reqReady=01 same cycle; next cycle regWrite=1, wrReg=5, wrData=0xDEADBEEF, pendMask=0x20.
- Persistent contention: reqValid=11 held for 6 cycles with distinct regs -> grants alternate 0,1,0,1,0,1; regWrite=1 on every following cycle; conflictCnt=6.
- Zero register: requester 1 writes reg 0 data 0x1234 -> reqReady[1]=1; next cycle regWrite=0, pendMask=0; the pointer still advances to 0.
- Idle gaps: requests on cycles 0 and 3 only -> regWrite=1 on cycles 1 and 4 only; wrReg/wrData hold during the gap.
- Async reset mid-burst: drop resetN between clock edges while regWrite=1 -> regWrite, pendMask and conflictCnt go to 0 immediately. After release, the first grant goes to requester 0.
- Saturation: force CNT_W=4, keep reqValid=11 for 20 cycles -> conflictCnt stops at 15.
